// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_wen,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [1:0]            d_size,
    input  logic                  d_zero_ex,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  m_req,
    output logic                  m_wen,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [1:0]            m_size,
    output logic                  m_zero_ex,
    input  logic                  m_ready,
    input  logic [DATA_WIDTH-1:0] m_rdata
);

    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;   // 1 = data requester owns the access
    logic [3:0]            starve_q, starve_d;
    logic                  m_req_q, m_req_d;
    logic                  m_wen_q, m_wen_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic [1:0]            m_size_q, m_size_d;
    logic                  m_zero_ex_q, m_zero_ex_d;
    logic                  i_rvalid_q, i_rvalid_d;
    logic                  d_rvalid_q, d_rvalid_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  starved_s;
    logic                  i_gnt_s;
    logic                  d_gnt_s;

    // Arbitration, next-state and registered-output next values.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        m_req_d     = 1'b0;
        m_wen_d     = m_wen_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_size_d    = m_size_q;
        m_zero_ex_d = m_zero_ex_q;
        i_rvalid_d  = 1'b0;
        d_rvalid_d  = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_gnt_s     = 1'b0;
        d_gnt_s     = 1'b0;
        starved_s   = i_req && (starve_q == STARVE_MAX);

        case (state_q)
            IDLE: begin
                if (d_req && !starved_s) begin
                    d_gnt_s     = 1'b1;
                    owner_d     = 1'b1;
                    state_d     = BUSY;
                    m_req_d     = 1'b1;
                    m_wen_d     = d_wen;
                    m_addr_d    = d_addr;
                    m_wdata_d   = d_wdata;
                    m_size_d    = d_size;
                    m_zero_ex_d = d_zero_ex;
                    if (!i_req) begin
                        starve_d = 4'd0;
                    end else if (starve_q == STARVE_MAX) begin
                        starve_d = starve_q;
                    end else begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (i_req) begin
                    i_gnt_s     = 1'b1;
                    owner_d     = 1'b0;
                    state_d     = BUSY;
                    starve_d    = 4'd0;
                    m_req_d     = 1'b1;
                    m_wen_d     = 1'b0;
                    m_addr_d    = i_addr;
                    m_wdata_d   = {DATA_WIDTH{1'b0}};
                    m_size_d    = SIZE_WORD;
                    m_zero_ex_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (m_ready) begin
                    state_d = RESP;
                    if (owner_q) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = m_rdata;
                    end else begin
                        i_rvalid_d = 1'b1;
                        i_rdata_d  = m_rdata;
                    end
                end else begin
                    m_req_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            starve_q    <= 4'd0;
            m_req_q     <= 1'b0;
            m_wen_q     <= 1'b0;
            m_addr_q    <= {ADDR_WIDTH{1'b0}};
            m_wdata_q   <= {DATA_WIDTH{1'b0}};
            m_size_q    <= SIZE_WORD;
            m_zero_ex_q <= 1'b1;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            i_rdata_q   <= {DATA_WIDTH{1'b0}};
            d_rdata_q   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            m_req_q     <= m_req_d;
            m_wen_q     <= m_wen_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_size_q    <= m_size_d;
            m_zero_ex_q <= m_zero_ex_d;
            i_rvalid_q  <= i_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Grants are combinational and suppressed while reset is held.
    assign i_gnt     = i_gnt_s && !res;
    assign d_gnt     = d_gnt_s && !res;
    assign i_rvalid  = i_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign m_req     = m_req_q;
    assign m_wen     = m_wen_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_size    = m_size_q;
    assign m_zero_ex = m_zero_ex_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus hand-written
// sequences for contention, starvation, mid-access reset and long stalls.
module tb_mem_port_arbiter;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic        clk = 1'b0;
    logic        res;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_wen, d_zero_ex, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic        m_req, m_wen, m_zero_ex, m_ready;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  m_size;

    typedef struct {
        logic        is_d;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        zx;
        int          lat;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
    } resp_t;

    resp_t sb[$];
    vec_t  tbl[6];
    vec_t  v;
    int    total = 0;
    int    bad   = 0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .res(res),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_zero_ex(d_zero_ex), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size),
        .m_zero_ex(m_zero_ex), .m_ready(m_ready), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic is_d, input logic wen, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] size, input logic zx,
                                input int lat, input logic [31:0] rdata);
        vec_t r;
        r.is_d = is_d; r.wen = wen; r.addr = addr; r.wdata = wdata;
        r.size = size; r.zx = zx; r.lat = lat; r.rdata = rdata;
        return r;
    endfunction

    // One complete access from IDLE back to IDLE; the winner's request stays high until the end.
    task automatic access(input vec_t a);
        resp_t       e;
        logic        ewen, ezx;
        logic [31:0] ewd;
        logic [1:0]  esz;
        if (a.is_d) begin
            d_req = 1'b1; d_wen = a.wen; d_addr = a.addr; d_wdata = a.wdata;
            d_size = a.size; d_zero_ex = a.zx;
        end else begin
            i_req = 1'b1; i_addr = a.addr;
        end
        ewen = a.is_d ? a.wen   : 1'b0;
        ewd  = a.is_d ? a.wdata : 32'h0;
        esz  = a.is_d ? a.size  : SZ_W;
        ezx  = a.is_d ? a.zx    : 1'b1;
        m_ready = 1'b0;
        #1;
        chk("gnt_i", i_gnt, !a.is_d);
        chk("gnt_d", d_gnt, a.is_d);
        chk("m_req_idle", m_req, 1'b0);
        e.is_d = a.is_d; e.rdata = a.rdata;
        sb.push_back(e);
        step();
        for (int k = 1; k <= a.lat; k++) begin
            m_ready = (k == a.lat);
            m_rdata = (k == a.lat) ? a.rdata : ~a.rdata;
            #1;
            chk("m_req_busy", m_req, 1'b1);
            chk("m_addr", m_addr, a.addr);
            chk("m_wen", m_wen, ewen);
            chk("m_wdata", m_wdata, ewd);
            chk("m_size", m_size, esz);
            chk("m_zero_ex", m_zero_ex, ezx);
            chk("busy_gnt", {i_gnt, d_gnt}, 2'b00);
            chk("busy_rvalid", {i_rvalid, d_rvalid}, 2'b00);
            step();
        end
        m_ready = 1'b0;
        #1;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 1'b0, 1'b1);
        end else begin
            e = sb.pop_front();
            chk("rvalid_i", i_rvalid, !e.is_d);
            chk("rvalid_d", d_rvalid, e.is_d);
            chk("rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
        end
        chk("m_req_resp", m_req, 1'b0);
        chk("resp_gnt", {i_gnt, d_gnt}, 2'b00);
        step();
        chk("rvalid_pulse", {i_rvalid, d_rvalid}, 2'b00);
        if (a.is_d) d_req = 1'b0;
        else        i_req = 1'b0;
    endtask

    initial begin
        tbl[0] = mk(1'b0, 1'b0, 32'h10, 32'h0,        SZ_W, 1'b1, 2, 32'h00500093);
        tbl[1] = mk(1'b1, 1'b0, 32'h80, 32'h0,        SZ_B, 1'b0, 1, 32'h000000A5);
        tbl[2] = mk(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, SZ_W, 1'b1, 1, 32'h11112222);
        tbl[3] = mk(1'b1, 1'b0, 32'h84, 32'h0,        SZ_H, 1'b1, 3, 32'h0000BEEF);
        tbl[4] = mk(1'b0, 1'b0, 32'h14, 32'h0,        SZ_W, 1'b1, 1, 32'h00A00113);
        tbl[5] = mk(1'b1, 1'b0, 32'h90, 32'h0,        SZ_W, 1'b1, 4, 32'hCAFEF00D);

        res = 1'b1; i_req = 1'b1; d_req = 1'b1; i_addr = 32'h4; d_addr = 32'h8;
        d_wen = 1'b1; d_wdata = 32'h5; d_size = SZ_B; d_zero_ex = 1'b0;
        m_ready = 1'b1; m_rdata = 32'h77;
        step();
        step();
        chk("rst_gnt", {i_gnt, d_gnt}, 2'b00);
        chk("rst_m_req", m_req, 1'b0);
        chk("rst_m_wen", m_wen, 1'b0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        chk("rst_m_size", m_size, SZ_W);
        chk("rst_m_zero_ex", m_zero_ex, 1'b1);
        chk("rst_rvalid", {i_rvalid, d_rvalid}, 2'b00);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
        res = 1'b0;
        step();
        chk("idle_no_req", {i_gnt, d_gnt, m_req}, 3'b000);

        for (int n = 0; n < 6; n++) access(tbl[n]);

        // Contention: data wins first, fetch follows in the next IDLE.
        i_req = 1'b1; i_addr = 32'h20;
        access(mk(1'b1, 1'b0, 32'h80, 32'h0, SZ_B, 1'b0, 1, 32'h000000FF));
        access(mk(1'b0, 1'b0, 32'h20, 32'h0, SZ_W, 1'b1, 2, 32'h00000013));

        // Starvation: D,D,D,D then forced I, then D again.
        i_req = 1'b1; i_addr = 32'h30;
        for (int n = 0; n < 4; n++)
            access(mk(1'b1, 1'b0, 32'h100 + 32'(n * 4), 32'h0, SZ_W, 1'b1, 1, 32'h1000 + 32'(n)));
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h200; d_size = SZ_W; d_zero_ex = 1'b1;
        access(mk(1'b0, 1'b0, 32'h30, 32'h0, SZ_W, 1'b1, 1, 32'h00300093));
        i_req = 1'b1;
        access(mk(1'b1, 1'b0, 32'h200, 32'h0, SZ_W, 1'b1, 1, 32'h2000));
        i_req = 1'b0;

        // Long stall with both requests high.
        i_req = 1'b1; i_addr = 32'h34;
        access(mk(1'b1, 1'b1, 32'h300, 32'h12345678, SZ_H, 1'b0, 11, 32'h0));
        access(mk(1'b0, 1'b0, 32'h34, 32'h0, SZ_W, 1'b1, 1, 32'h00400093));

        // Reset during BUSY abandons the access; pending fetch is granted afterwards.
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h44; d_size = SZ_W; d_zero_ex = 1'b1;
        #1;
        chk("rr_d_gnt", d_gnt, 1'b1);
        step();
        d_req = 1'b0; i_req = 1'b1; i_addr = 32'h50; res = 1'b1;
        #1;
        chk("rr_gnt_in_res", {i_gnt, d_gnt}, 2'b00);
        step();
        res = 1'b0; m_ready = 1'b1; m_rdata = 32'hBADBAD00;
        #1;
        chk("rr_m_req", m_req, 1'b0);
        chk("rr_m_addr", m_addr, 32'h0);
        chk("rr_rvalid", {i_rvalid, d_rvalid}, 2'b00);
        chk("rr_d_rdata", d_rdata, 32'h0);
        chk("rr_i_gnt", i_gnt, 1'b1);
        step();
        chk("rr_no_rvalid", {i_rvalid, d_rvalid}, 2'b00);
        m_ready = 1'b1; m_rdata = 32'h00700093;
        #1;
        chk("rr_m_addr2", m_addr, 32'h50);
        chk("rr_m_req2", m_req, 1'b1);
        step();
        m_ready = 1'b0; i_req = 1'b0;
        chk("rr_i_rvalid", i_rvalid, 1'b1);
        chk("rr_i_rdata", i_rdata, 32'h00700093);
        chk("rr_d_rvalid", d_rvalid, 1'b0);
        step();
        chk("rr_idle", {m_req, i_rvalid, d_rvalid}, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
